// File: rtl/dbg_apb_arb_if.sv
// dbg_apb_arb_if: bundles the two debug requester ports and the shared APB
// slave port of dbg_apb_arb. The arbiter uses the slave modport; the
// environment that drives requesters and models the APB slave uses master.
interface dbg_apb_arb_if;
    // Requester 0
    logic        i_m0_penable;
    logic        i_m0_pwrite;
    logic [31:0] i_m0_paddr;
    logic [31:0] i_m0_pwdata;
    logic        o_m0_pready;
    logic [31:0] o_m0_prdata;
    logic        o_m0_err;
    // Requester 1
    logic        i_m1_penable;
    logic        i_m1_pwrite;
    logic [31:0] i_m1_paddr;
    logic [31:0] i_m1_pwdata;
    logic        o_m1_pready;
    logic [31:0] o_m1_prdata;
    logic        o_m1_err;
    // Sticky dropped-request flags, one per requester
    logic [1:0]  o_ovf;
    // Shared APB slave side
    logic        o_penable;
    logic        o_pwrite;
    logic [31:0] o_paddr;
    logic [31:0] o_pwdata;
    logic        i_pready;
    logic [31:0] i_prdata;

    modport slave (
        input  i_m0_penable, i_m0_pwrite, i_m0_paddr, i_m0_pwdata,
        output o_m0_pready, o_m0_prdata, o_m0_err,
        input  i_m1_penable, i_m1_pwrite, i_m1_paddr, i_m1_pwdata,
        output o_m1_pready, o_m1_prdata, o_m1_err,
        output o_ovf,
        output o_penable, o_pwrite, o_paddr, o_pwdata,
        input  i_pready, i_prdata
    );

    modport master (
        output i_m0_penable, i_m0_pwrite, i_m0_paddr, i_m0_pwdata,
        input  o_m0_pready, o_m0_prdata, o_m0_err,
        output i_m1_penable, i_m1_pwrite, i_m1_paddr, i_m1_pwdata,
        input  o_m1_pready, o_m1_prdata, o_m1_err,
        input  o_ovf,
        input  o_penable, o_pwrite, o_paddr, o_pwdata,
        output i_pready, i_prdata
    );
endinterface

// File: rtl/dbg_apb_arb.sv
// dbg_apb_arb: arbitrates two debug requesters onto one APB slave.
// Each requester strobe is captured into a private register; a three-state
// FSM (IDLE -> ACCESS -> RESP) grants one requester at a time, round-robin
// when both are pending, and aborts an access that waits too long for the
// slave, returning ERR_DATA with an error pulse.
module dbg_apb_arb #(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    dbg_apb_arb_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Counter value on the last ACCESS cycle allowed before abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    // Requester inputs gathered into indexable form
    logic [1:0]  w_pen;
    logic [1:0]  w_pwr;
    logic [31:0] w_addr  [2];
    logic [31:0] w_wdata [2];

    // Per-requester capture state
    logic [1:0]  r_busy;
    logic [1:0]  r_pen_d;
    logic [1:0]  r_ovf;
    logic [1:0]  r_cap_wr;
    logic [31:0] r_cap_addr  [2];
    logic [31:0] r_cap_wdata [2];

    // Arbitration and transfer state
    logic        r_gnt;
    logic        r_rr_ptr;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;

    logic        w_grant;
    logic        w_gnt_sel;
    logic        w_acc_done;
    logic        w_timeout;
    logic [1:0]  w_resp;

    assign w_pen      = {bus.i_m1_penable, bus.i_m0_penable};
    assign w_pwr      = {bus.i_m1_pwrite,  bus.i_m0_pwrite};
    assign w_addr[0]  = bus.i_m0_paddr;
    assign w_addr[1]  = bus.i_m1_paddr;
    assign w_wdata[0] = bus.i_m0_pwdata;
    assign w_wdata[1] = bus.i_m1_pwdata;

    assign w_resp[0]  = (r_state == RESP) && !r_gnt;
    assign w_resp[1]  = (r_state == RESP) &&  r_gnt;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: all clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, grant selection and ACCESS termination decode
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_sel   = r_rr_ptr;
        w_acc_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                // Nothing is granted in IDLE, so every busy requester is pending.
                if (|r_busy) begin
                    w_grant     = 1'b1;
                    w_gnt_sel   = (r_busy == 2'b11) ? r_rr_ptr : r_busy[1];
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.i_pready) begin
                    w_acc_done  = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Per-requester capture, busy tracking and sticky overflow detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: the capture registers are plain flops, not a RAM, so they are
        // reset like the rest of the state and never expose stale data.
        if (!i_rst_n) begin
            r_busy   <= '0;
            r_pen_d  <= '0;
            r_ovf    <= '0;
            r_cap_wr <= '0;
            for (int n = 0; n < 2; n++) begin
                r_cap_addr[n]  <= '0;
                r_cap_wdata[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                r_pen_d[n] <= w_pen[n];
                if (w_pen[n] && !r_busy[n]) begin
                    r_busy[n]      <= 1'b1;
                    r_cap_wr[n]    <= w_pwr[n];
                    r_cap_addr[n]  <= w_addr[n];
                    r_cap_wdata[n] <= w_wdata[n];
                end else if (w_resp[n]) begin
                    // Completion cycle: a strobe here is ignored outright.
                    r_busy[n] <= 1'b0;
                end else if (w_pen[n] && !r_pen_d[n] && r_busy[n]) begin
                    // A fresh strobe while still busy cannot be queued.
                    r_ovf[n] <= 1'b1;
                end
            end
        end
    end

    // Shared APB drive, timeout counting, response latching and rr pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt     <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            if (w_grant) begin
                r_gnt     <= w_gnt_sel;
                r_penable <= 1'b1;
                r_pwrite  <= r_cap_wr[w_gnt_sel];
                r_paddr   <= r_cap_addr[w_gnt_sel];
                r_pwdata  <= r_cap_wdata[w_gnt_sel];
                r_cnt     <= '0;
            end else if (w_acc_done || w_timeout) begin
                // Bus returns to all-zero once the access ends.
                r_penable <= 1'b0;
                r_pwrite  <= 1'b0;
                r_paddr   <= '0;
                r_pwdata  <= '0;
                r_rdata   <= w_acc_done ? bus.i_prdata : ERR_DATA;
                r_err     <= w_timeout;
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == RESP) begin
                r_rr_ptr <= ~r_gnt;
            end
        end
    end

    // Responses are decoded from RESP so they are zero in every other state.
    assign bus.o_m0_pready = w_resp[0];
    assign bus.o_m0_prdata = (w_resp[0] && !r_cap_wr[0]) ? r_rdata : '0;
    assign bus.o_m0_err    = w_resp[0] && r_err;
    assign bus.o_m1_pready = w_resp[1];
    assign bus.o_m1_prdata = (w_resp[1] && !r_cap_wr[1]) ? r_rdata : '0;
    assign bus.o_m1_err    = w_resp[1] && r_err;
    assign bus.o_ovf       = r_ovf;
    assign bus.o_penable   = r_penable;
    assign bus.o_pwrite    = r_pwrite;
    assign bus.o_paddr     = r_paddr;
    assign bus.o_pwdata    = r_pwdata;

endmodule

// File: tb/tb_dbg_apb_arb.sv
// tb_dbg_apb_arb: directed scenarios for dbg_apb_arb with hand-computed
// cycle-by-cycle expectations. Cycle 0 is the cycle a strobe is driven.
module tb_dbg_apb_arb;

    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dbg_apb_arb_if bus ();

    dbg_apb_arb #(
        .TIMEOUT_CYC (TO),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_m0_penable = 1'b0; bus.i_m0_pwrite = 1'b0;
        bus.i_m0_paddr   = '0;   bus.i_m0_pwdata = '0;
        bus.i_m1_penable = 1'b0; bus.i_m1_pwrite = 1'b0;
        bus.i_m1_paddr   = '0;   bus.i_m1_pwdata = '0;
        bus.i_pready     = 1'b0; bus.i_prdata    = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.i_m0_penable = 1'b1;
        bus.i_pready     = 1'b1;
        tick();
        tick();
        n_cmp++; if ({bus.o_penable, bus.o_pwrite} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %0h want 0", {bus.o_penable, bus.o_pwrite}); end
        n_cmp++; if ({bus.o_paddr, bus.o_pwdata} !== 64'h0) begin n_err++; $display("FAIL reset_addr_data: got %0h want 0", {bus.o_paddr, bus.o_pwdata}); end
        n_cmp++; if ({bus.o_m0_pready, bus.o_m0_err, bus.o_m1_pready, bus.o_m1_err} !== 4'h0) begin n_err++; $display("FAIL reset_pready_err: got %0h want 0", {bus.o_m0_pready, bus.o_m0_err, bus.o_m1_pready, bus.o_m1_err}); end
        n_cmp++; if ({bus.o_m0_prdata, bus.o_m1_prdata} !== 64'h0) begin n_err++; $display("FAIL reset_prdata: got %0h want 0", {bus.o_m0_prdata, bus.o_m1_prdata}); end
        n_cmp++; if (bus.o_ovf !== 2'b00) begin n_err++; $display("FAIL reset_ovf: got %0h want 0", bus.o_ovf); end
    endtask

    task automatic test_read();
        do_reset();
        bus.i_m0_penable = 1'b1; bus.i_m0_pwrite = 1'b0; bus.i_m0_paddr = 32'h0000_0010;
        tick(); // cycle 1
        bus.i_m0_penable = 1'b0;
        n_cmp++; if (bus.o_penable !== 1'b0) begin n_err++; $display("FAIL read_c1_penable: got %0h want 0", bus.o_penable); end
        tick(); // cycle 2
        n_cmp++; if (bus.o_penable !== 1'b1) begin n_err++; $display("FAIL read_c2_penable: got %0h want 1", bus.o_penable); end
        n_cmp++; if (bus.o_paddr !== 32'h0000_0010) begin n_err++; $display("FAIL read_c2_paddr: got %0h want 10", bus.o_paddr); end
        n_cmp++; if (bus.o_pwrite !== 1'b0) begin n_err++; $display("FAIL read_c2_pwrite: got %0h want 0", bus.o_pwrite); end
        bus.i_pready = 1'b1; bus.i_prdata = 32'h1234_5678;
        tick(); // cycle 3
        bus.i_pready = 1'b0; bus.i_prdata = '0;
        n_cmp++; if (bus.o_m0_pready !== 1'b1) begin n_err++; $display("FAIL read_c3_pready: got %0h want 1", bus.o_m0_pready); end
        n_cmp++; if (bus.o_m0_prdata !== 32'h1234_5678) begin n_err++; $display("FAIL read_c3_prdata: got %0h want 12345678", bus.o_m0_prdata); end
        n_cmp++; if ({bus.o_m0_err, bus.o_m1_pready, bus.o_penable} !== 3'b000) begin n_err++; $display("FAIL read_c3_err_m1_pen: got %0h want 0", {bus.o_m0_err, bus.o_m1_pready, bus.o_penable}); end
        tick(); // cycle 4
        n_cmp++; if ({bus.o_m0_pready, bus.o_m0_prdata} !== 33'h0) begin n_err++; $display("FAIL read_c4_idle: got %0h want 0", {bus.o_m0_pready, bus.o_m0_prdata}); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] s_addr  [8];
        logic [31:0] s_wdata [8];
        logic        s_wr    [8];
        int s_n  = 0;
        int p0   = 0;
        int p1   = 0;
        int viol = 0;
        do_reset();
        bus.i_prdata = 32'hFFFF_FFFF;
        bus.i_m0_penable = 1'b1; bus.i_m0_pwrite = 1'b1; bus.i_m0_paddr = 32'h100; bus.i_m0_pwdata = 32'hA0A0_0001;
        bus.i_m1_penable = 1'b1; bus.i_m1_pwrite = 1'b1; bus.i_m1_paddr = 32'h200; bus.i_m1_pwdata = 32'hB1B1_0002;
        for (int c = 1; c <= 12; c++) begin
            tick();
            bus.i_m0_penable = 1'b0;
            bus.i_m1_penable = (c == 1); // held strobe, must not flag overflow
            if (bus.o_penable && s_n < 8) begin
                s_addr[s_n] = bus.o_paddr; s_wdata[s_n] = bus.o_pwdata; s_wr[s_n] = bus.o_pwrite;
                s_n++;
            end
            bus.i_pready = bus.o_penable;
            if (bus.o_m0_pready) begin p0++; if (bus.o_m0_prdata !== 32'h0) viol++; end
            if (bus.o_m1_pready) begin p1++; if (bus.o_m1_prdata !== 32'h0) viol++; end
            if (!bus.o_penable && (bus.o_pwrite !== 1'b0 || bus.o_pwdata !== 32'h0)) viol++;
        end
        bus.i_pready = 1'b0;
        n_cmp++; if (s_n !== 2) begin n_err++; $display("FAIL sim_access_count: got %0d want 2", s_n); end
        n_cmp++; if ({s_addr[0], s_wdata[0], s_wr[0]} !== {32'h100, 32'hA0A0_0001, 1'b1}) begin n_err++; $display("FAIL sim_first_m0: got %0h want %0h", {s_addr[0], s_wdata[0], s_wr[0]}, {32'h100, 32'hA0A0_0001, 1'b1}); end
        n_cmp++; if ({s_addr[1], s_wdata[1], s_wr[1]} !== {32'h200, 32'hB1B1_0002, 1'b1}) begin n_err++; $display("FAIL sim_second_m1: got %0h want %0h", {s_addr[1], s_wdata[1], s_wr[1]}, {32'h200, 32'hB1B1_0002, 1'b1}); end
        n_cmp++; if (p0 !== 1 || p1 !== 1) begin n_err++; $display("FAIL sim_pready_pulses: got %0d/%0d want 1/1", p0, p1); end
        n_cmp++; if (bus.o_ovf !== 2'b00) begin n_err++; $display("FAIL sim_ovf: got %0h want 0", bus.o_ovf); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL sim_idle_bus_and_write_prdata: got %0d violations want 0", viol); end
    endtask

    task automatic test_round_robin();
        int seq [8];
        int n    = 0;
        int np   = 0;
        int bad  = 0;
        int iss0 = 1;
        int iss1 = 1;
        bit re0  = 1'b0;
        bit re1  = 1'b0;
        logic [31:0] exp_rd = '0;
        do_reset();
        bus.i_m0_penable = 1'b1; bus.i_m0_pwrite = 1'b0; bus.i_m0_paddr = 32'h1000;
        bus.i_m1_penable = 1'b1; bus.i_m1_pwrite = 1'b0; bus.i_m1_paddr = 32'h2000;
        for (int c = 1; c <= 80 && np < 8; c++) begin
            tick();
            bus.i_m0_penable = re0;
            if (re0) begin bus.i_m0_paddr = 32'h1000 + 32'(iss0); iss0++; end
            bus.i_m1_penable = re1;
            if (re1) begin bus.i_m1_paddr = 32'h2000 + 32'(iss1); iss1++; end
            re0 = 1'b0;
            re1 = 1'b0;
            if (bus.o_penable) begin
                if (n < 8) seq[n] = (bus.o_paddr[15:12] == 4'h2) ? 1 : 0;
                n++;
                exp_rd       = ~bus.o_paddr;
                bus.i_prdata = ~bus.o_paddr;
            end
            bus.i_pready = bus.o_penable;
            if (bus.o_m0_pready) begin np++; if (bus.o_m0_prdata !== exp_rd) bad++; if (iss0 < 4) re0 = 1'b1; end
            if (bus.o_m1_pready) begin np++; if (bus.o_m1_prdata !== exp_rd) bad++; if (iss1 < 4) re1 = 1'b1; end
        end
        bus.i_pready = 1'b0;
        n_cmp++; if (np !== 8) begin n_err++; $display("FAIL rr_completions: got %0d want 8 within budget", np); end
        n_cmp++; if (n !== 8) begin n_err++; $display("FAIL rr_accesses: got %0d want 8", n); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (seq[i] !== (i % 2)) begin n_err++; $display("FAIL rr_grant_%0d: got m%0d want m%0d", i, seq[i], i % 2); end
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rr_prdata: got %0d wrong want 0", bad); end
        n_cmp++; if (bus.o_ovf !== 2'b00) begin n_err++; $display("FAIL rr_ovf: got %0h want 0", bus.o_ovf); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.i_prdata = 32'h5555_5555;
        bus.i_m1_penable = 1'b1; bus.i_m1_pwrite = 1'b0; bus.i_m1_paddr = 32'h300;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.i_m1_penable = 1'b0;
            n_cmp++; if (bus.o_penable !== (c >= 2 && c <= 1 + TO)) begin n_err++; $display("FAIL to_penable_c%0d: got %0h want %0h", c, bus.o_penable, (c >= 2 && c <= 1 + TO)); end
            n_cmp++; if ({bus.o_m1_pready, bus.o_m1_err} !== {2{c == 2 + TO}}) begin n_err++; $display("FAIL to_pready_err_c%0d: got %0h want %0h", c, {bus.o_m1_pready, bus.o_m1_err}, {2{c == 2 + TO}}); end
            if (c == 2 + TO) begin
                n_cmp++; if (bus.o_m1_prdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL to_prdata: got %0h want deadbeef", bus.o_m1_prdata); end
            end
            n_cmp++; if (bus.o_m0_pready !== 1'b0) begin n_err++; $display("FAIL to_m0_pready_c%0d: got %0h want 0", c, bus.o_m0_pready); end
        end
    endtask

    task automatic test_overflow();
        int n_acc = 0;
        int p0    = 0;
        do_reset();
        bus.i_m0_penable = 1'b1; bus.i_m0_pwrite = 1'b1; bus.i_m0_paddr = 32'h400; bus.i_m0_pwdata = 32'h11;
        tick(); // cycle 1
        bus.i_m0_penable = 1'b0;
        tick(); // cycle 2: re-strobe while busy
        bus.i_m0_penable = 1'b1; bus.i_m0_paddr = 32'h500; bus.i_m0_pwdata = 32'h22;
        n_cmp++; if ({bus.o_penable, bus.o_paddr} !== {1'b1, 32'h400}) begin n_err++; $display("FAIL ovf_c2_access: got %0h want %0h", {bus.o_penable, bus.o_paddr}, {1'b1, 32'h400}); end
        tick(); // cycle 3
        bus.i_m0_penable = 1'b0;
        n_cmp++; if (bus.o_ovf !== 2'b01) begin n_err++; $display("FAIL ovf_c3_flag: got %0h want 1", bus.o_ovf); end
        n_cmp++; if ({bus.o_paddr, bus.o_pwdata} !== {32'h400, 32'h11}) begin n_err++; $display("FAIL ovf_c3_stable: got %0h want %0h", {bus.o_paddr, bus.o_pwdata}, {32'h400, 32'h11}); end
        bus.i_pready = 1'b1;
        for (int c = 4; c <= 12; c++) begin
            tick();
            if (bus.o_penable) n_acc++;
            bus.i_pready = bus.o_penable;
            if (bus.o_m0_pready) p0++;
        end
        bus.i_pready = 1'b0;
        n_cmp++; if (n_acc !== 0) begin n_err++; $display("FAIL ovf_extra_access: got %0d want 0", n_acc); end
        n_cmp++; if (p0 !== 1) begin n_err++; $display("FAIL ovf_pready_count: got %0d want 1", p0); end
        n_cmp++; if (bus.o_ovf !== 2'b01) begin n_err++; $display("FAIL ovf_sticky: got %0h want 1", bus.o_ovf); end
    endtask

    task automatic test_reset_mid();
        int pr = 0;
        do_reset();
        bus.i_m0_penable = 1'b1; bus.i_m0_pwrite = 1'b0; bus.i_m0_paddr = 32'h600;
        tick(); // cycle 1
        bus.i_m0_penable = 1'b0;
        tick(); // cycle 2: in ACCESS
        n_cmp++; if (bus.o_penable !== 1'b1) begin n_err++; $display("FAIL rmid_in_access: got %0h want 1", bus.o_penable); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.o_penable, bus.o_paddr} !== 33'h0) begin n_err++; $display("FAIL rmid_async_clear: got %0h want 0", {bus.o_penable, bus.o_paddr}); end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.o_m0_pready || bus.o_m1_pready) pr++;
        end
        rst_n = 1'b1;
        n_cmp++; if (pr !== 0) begin n_err++; $display("FAIL rmid_no_pready: got %0d want 0", pr); end
        bus.i_m1_penable = 1'b1; bus.i_m1_pwrite = 1'b1; bus.i_m1_paddr = 32'h700; bus.i_m1_pwdata = 32'h77;
        tick(); // cycle 1
        bus.i_m1_penable = 1'b0;
        tick(); // cycle 2
        n_cmp++; if ({bus.o_penable, bus.o_pwrite, bus.o_paddr, bus.o_pwdata} !== {1'b1, 1'b1, 32'h700, 32'h77}) begin n_err++; $display("FAIL rmid_next_access: got %0h want %0h", {bus.o_penable, bus.o_pwrite, bus.o_paddr, bus.o_pwdata}, {1'b1, 1'b1, 32'h700, 32'h77}); end
        bus.i_pready = 1'b1; bus.i_prdata = 32'hCAFE_0000;
        tick(); // cycle 3
        bus.i_pready = 1'b0;
        n_cmp++; if ({bus.o_m1_pready, bus.o_m1_err, bus.o_m1_prdata, bus.o_m0_pready} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin n_err++; $display("FAIL rmid_next_resp: got %0h want %0h", {bus.o_m1_pready, bus.o_m1_err, bus.o_m1_prdata, bus.o_m0_pready}, {1'b1, 1'b0, 32'h0, 1'b0}); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_read();
        test_simultaneous();
        test_round_robin();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
